// File: rtl/dtw_result_packer.sv
// ============================================================================
// dtw_result_packer: buffers DTW results and emits each as a 3-beat AXI-Stream packet.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dtw_result_packer #(
    parameter int dtw_dwidth     = 16,
    parameter int axi_dwidth     = 32,
    parameter int RES_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sink_fifo_wren,
    output logic                      sink_fifo_full,
    input  logic [dtw_dwidth-1:0]     sink_minval,
    input  logic [31:0]               sink_position,
    input  logic [31:0]               sink_qid,
    output logic [axi_dwidth-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [RES_DEPTH_LOG2:0]   res_count,
    output logic                      overflow
);

    localparam int                        c_DEPTH     = 1 << RES_DEPTH_LOG2;
    localparam logic [RES_DEPTH_LOG2:0]   c_CNT_FULL  = (RES_DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [RES_DEPTH_LOG2:0]   c_CNT_ONE   = (RES_DEPTH_LOG2+1)'(1);
    localparam logic [RES_DEPTH_LOG2-1:0] c_PTR_ONE   = RES_DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BEAT_QID = 2'd1,
        S_BEAT_POS = 2'd2,
        S_BEAT_VAL = 2'd3
    } state_t;

    logic [31:0]               r_mem_qid    [c_DEPTH];
    logic [31:0]               r_mem_pos    [c_DEPTH];
    logic [dtw_dwidth-1:0]     r_mem_minval [c_DEPTH];

    logic [RES_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [RES_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [RES_DEPTH_LOG2:0]   r_count;
    logic                      r_overflow;
    state_t                    r_state;

    logic                      w_push;
    logic                      w_pop;
    logic [RES_DEPTH_LOG2:0]   w_count_nxt;
    logic [RES_DEPTH_LOG2-1:0] w_rd_ptr_inc;
    logic [31:0]               w_next_qid;
    logic [axi_dwidth-1:0]     w_minval_ext;

    // Full comes from the registered count only, so a same-cycle pop never admits a write.
    assign sink_fifo_full = (r_count == c_CNT_FULL);
    assign res_count      = r_count;
    assign overflow       = r_overflow;

    assign w_push       = sink_fifo_wren && !sink_fifo_full;
    assign w_pop        = (r_state == S_BEAT_VAL) && m_axis_tvalid && m_axis_tready;
    assign w_rd_ptr_inc = r_rd_ptr + c_PTR_ONE;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // With one entry left, the next head is the entry being written this very edge.
    assign w_next_qid = (r_count == c_CNT_ONE) ? sink_qid : r_mem_qid[w_rd_ptr_inc];

    always_comb begin
        w_minval_ext                   = '0;
        w_minval_ext[dtw_dwidth-1:0]   = r_mem_minval[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_qid[r_wr_ptr]    <= sink_qid;
            r_mem_pos[r_wr_ptr]    <= sink_position;
            r_mem_minval[r_wr_ptr] <= sink_minval;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
            if (sink_fifo_wren && sink_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state       <= S_BEAT_QID;
                        m_axis_tdata  <= axi_dwidth'(r_mem_qid[r_rd_ptr]);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                S_BEAT_QID: begin
                    if (m_axis_tready) begin
                        r_state      <= S_BEAT_POS;
                        m_axis_tdata <= axi_dwidth'(r_mem_pos[r_rd_ptr]);
                    end
                end
                S_BEAT_POS: begin
                    if (m_axis_tready) begin
                        r_state      <= S_BEAT_VAL;
                        m_axis_tdata <= w_minval_ext;
                        m_axis_tlast <= 1'b1;
                    end
                end
                S_BEAT_VAL: begin
                    if (m_axis_tready) begin
                        m_axis_tlast <= 1'b0;
                        if (w_count_nxt != '0) begin
                            r_state      <= S_BEAT_QID;
                            m_axis_tdata <= axi_dwidth'(w_next_qid);
                        end else begin
                            r_state       <= S_IDLE;
                            m_axis_tvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dtw_result_packer.sv
// ============================================================================
// tb_dtw_result_packer: randomized self-checking bench with a packet-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dtw_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sink_fifo_wren;
    logic        sink_fifo_full;
    logic [15:0] sink_minval;
    logic [31:0] sink_position;
    logic [31:0] sink_qid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [4:0]  res_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];

    dtw_result_packer #(
        .dtw_dwidth     (16),
        .axi_dwidth     (32),
        .RES_DEPTH_LOG2 (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .sink_fifo_wren (sink_fifo_wren),
        .sink_fifo_full (sink_fifo_full),
        .sink_minval    (sink_minval),
        .sink_position  (sink_position),
        .sink_qid       (sink_qid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .res_count      (res_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so this view matches what the next edge captures.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every accepted result becomes qid, position, zero-extended minval (last).
    task automatic model_push(input logic [31:0] q, input logic [31:0] p, input logic [15:0] m);
        exp_d.push_back(q);
        exp_l.push_back(1'b0);
        exp_d.push_back(p);
        exp_l.push_back(1'b0);
        exp_d.push_back(32'(m));
        exp_l.push_back(1'b1);
    endtask

    task automatic clear_queues();
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic set_inputs(input logic [31:0] q, input logic [31:0] p, input logic [15:0] m);
        sink_qid      = q;
        sink_position = p;
        sink_minval   = m;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        sink_fifo_wren = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (got_d.size() >= exp_d.size() && !m_axis_tvalid) break;
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        sink_fifo_wren = 1'b1;
        m_axis_tready  = 1'b1;
        set_inputs($urandom, $urandom, 16'($urandom));
        tick();
        tick();
        sink_fifo_wren = 1'b0;
        rst = 1'b0;
        total++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'd0) begin
            bad++;
            $display("FAIL reset_stream: got valid=%b last=%b data=%h want 0/0/0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        total++;
        if ({sink_fifo_full, overflow, res_count} !== 7'd0) begin
            bad++;
            $display("FAIL reset_status: got full=%b ovf=%b count=%0d want 0/0/0",
                     sink_fifo_full, overflow, res_count);
        end
        clear_queues();
    endtask

    task automatic test_single();
        clear_queues();
        m_axis_tready = 1'b1;
        set_inputs(32'h5, 32'h1234, 16'h00FF);
        sink_fifo_wren = 1'b1;
        model_push(32'h5, 32'h1234, 16'h00FF);
        tick();
        sink_fifo_wren = 1'b0;
        total++;
        if (res_count !== 5'd1 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_after_push: got count=%0d valid=%b want 1/0", res_count, m_axis_tvalid);
        end
        tick();
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h5 || m_axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL single_beat0: got v=%b d=%h l=%b want 1/00000005/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        tick();
        total++;
        if (m_axis_tdata !== 32'h1234 || m_axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL single_beat1: got d=%h l=%b want 00001234/0", m_axis_tdata, m_axis_tlast);
        end
        tick();
        total++;
        if (m_axis_tdata !== 32'h000000FF || m_axis_tlast !== 1'b1) begin
            bad++;
            $display("FAIL single_beat2: got d=%h l=%b want 000000ff/1", m_axis_tdata, m_axis_tlast);
        end
        tick();
        total++;
        if (m_axis_tvalid !== 1'b0 || res_count !== 5'd0) begin
            bad++;
            $display("FAIL single_idle: got valid=%b count=%0d want 0/0", m_axis_tvalid, res_count);
        end
        total++;
        if (got_d.size() != 3) begin
            bad++;
            $display("FAIL single_beats: got %0d handshakes want 3", got_d.size());
        end
    endtask

    task automatic test_backpressure();
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        logic [31:0] q;
        clear_queues();
        m_axis_tready = 1'b0;
        q = $urandom;
        set_inputs(q, 32'h1234, 16'h00FF);
        sink_fifo_wren = 1'b1;
        model_push(q, 32'h1234, 16'h00FF);
        tick();
        sink_fifo_wren = 1'b0;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (prev_stall) begin
                total++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
                    bad++;
                    $display("FAIL bp_stable: cycle %0d got v=%b d=%h l=%b want 1/%h/%b",
                             c, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
                end
            end
            m_axis_tready = (c < 4) ? 1'b0 : ((c % 2) == 0);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
        end
        m_axis_tready = 1'b1;
        wait_drain(20);
        total++;
        if (got_d.size() != exp_d.size()) begin
            bad++;
            $display("FAIL bp_count: got %0d handshakes want %0d", got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] p;
        logic [15:0] m;
        clear_queues();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            p = $urandom;
            m = 16'($urandom);
            set_inputs(32'(i), p, m);
            sink_fifo_wren = 1'b1;
            if (i < 16) model_push(32'(i), p, m);
            tick();
            if (i == 14) begin
                total++;
                if (sink_fifo_full !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_not_full15: got full=%b want 0", sink_fifo_full);
                end
            end
            if (i == 15) begin
                total++;
                if (sink_fifo_full !== 1'b1 || res_count !== 5'd16) begin
                    bad++;
                    $display("FAIL fill_full16: got full=%b count=%0d want 1/16", sink_fifo_full, res_count);
                end
            end
        end
        sink_fifo_wren = 1'b0;
        total++;
        if (overflow !== 1'b1 || res_count !== 5'd16) begin
            bad++;
            $display("FAIL fill_overflow: got ovf=%b count=%0d want 1/16", overflow, res_count);
        end
        m_axis_tready = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (sink_fifo_full !== 1'b0 || res_count !== 5'd15) begin
            bad++;
            $display("FAIL fill_first_pop: got full=%b count=%0d want 0/15", sink_fifo_full, res_count);
        end
        wait_drain(200);
        total++;
        if (got_d.size() != 48) begin
            bad++;
            $display("FAIL fill_count: got %0d beats want 48", got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL fill_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL fill_sticky: got ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        logic [15:0] m;
        do_reset();
        m_axis_tready = 1'b1;
        p = $urandom;
        m = 16'($urandom);
        set_inputs(32'h1, p, m);
        sink_fifo_wren = 1'b1;
        model_push(32'h1, p, m);
        tick();
        sink_fifo_wren = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (m_axis_tlast) break;
            tick();
        end
        total++;
        if (m_axis_tlast !== 1'b1) begin
            bad++;
            $display("FAIL b2b_reach_val: got tlast=%b want 1", m_axis_tlast);
        end
        p = $urandom;
        m = 16'($urandom);
        set_inputs(32'hA, p, m);
        sink_fifo_wren = 1'b1;
        model_push(32'hA, p, m);
        tick();
        sink_fifo_wren = 1'b0;
        total++;
        if (res_count !== 5'd1 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA || m_axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL b2b_next_head: got count=%0d v=%b d=%h l=%b want 1/1/0000000a/0",
                     res_count, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        wait_drain(20);
        total++;
        if (got_d.size() != 6) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats want 6", got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int          pushed;
        logic [31:0] p;
        logic [15:0] m;
        clear_queues();
        pushed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pushed >= 40 && got_d.size() >= 120) break;
            m_axis_tready = 1'($urandom_range(0, 1));
            if (pushed < 40 && (pushed - got_d.size() / 3) < 15 && $urandom_range(0, 1) == 1) begin
                p = $urandom;
                m = 16'($urandom);
                set_inputs(32'(pushed), p, m);
                sink_fifo_wren = 1'b1;
                model_push(32'(pushed), p, m);
                pushed++;
            end else begin
                sink_fifo_wren = 1'b0;
            end
            tick();
        end
        sink_fifo_wren = 1'b0;
        m_axis_tready  = 1'b1;
        wait_drain(100);
        total++;
        if (pushed != 40 || got_d.size() != 120) begin
            bad++;
            $display("FAIL wrap_count: got pushed=%0d beats=%0d want 40/120", pushed, got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL wrap_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_overflow: got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p0;
        logic [31:0] p;
        logic [15:0] m;
        clear_queues();
        m_axis_tready = 1'b0;
        p0 = $urandom;
        for (int i = 0; i < 17; i++) begin
            set_inputs(32'(i + 100), (i == 0) ? p0 : $urandom, 16'($urandom));
            sink_fifo_wren = 1'b1;
            tick();
        end
        sink_fifo_wren = 1'b0;
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre_ovf: got ovf=%b want 1", overflow);
        end
        m_axis_tready = 1'b1;
        tick();
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p0 || m_axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL rmid_pos_beat: got v=%b d=%h l=%b want 1/%h/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, p0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || res_count !== 5'd0 ||
            overflow !== 1'b0 || sink_fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL rmid_cleared: got v=%b l=%b count=%0d ovf=%b full=%b want 0/0/0/0/0",
                     m_axis_tvalid, m_axis_tlast, res_count, overflow, sink_fifo_full);
        end
        clear_queues();
        p = $urandom;
        m = 16'($urandom);
        set_inputs(32'h77, p, m);
        sink_fifo_wren = 1'b1;
        model_push(32'h77, p, m);
        tick();
        sink_fifo_wren = 1'b0;
        wait_drain(20);
        total++;
        if (got_d.size() != 3) begin
            bad++;
            $display("FAIL rmid_count: got %0d beats want 3", got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        sink_fifo_wren = 1'b0;
        m_axis_tready  = 1'b0;
        set_inputs('0, '0, '0);
        test_reset();
        test_single();
        test_backpressure();
        test_fill_overflow();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
